mem_ctrl: RTL and testbench
===========================

MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 clk  in  1  single clock; all state changes on rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-low (0 = reset).
REQ-003 me_r_enable  in  1  data-side read request from memory stage.
REQ-004 me_w_enable  in  1  data-side write request from memory stage.
REQ-005 me_w_mask  in  4  byte-lane write mask, bit k = lane k.
REQ-006 me_w_data  in  32  store data, lane k = bits [8k+7:8k].
REQ-007 me_addr  in  32  data-side address; bits [1:0] ignored (word-aligned internally).
REQ-008 me_r_data  out  32  assembled read word for memory stage.
REQ-009 me_busy  out  1  data-side transaction in progress.
REQ-010 me_done  out  1  one-cycle pulse: data-side transaction complete.
REQ-011 if_r_enable  in  1  instruction-fetch read request.
REQ-012 if_addr  in  32  fetch address; bits [1:0] ignored.
REQ-013 if_r_data  out  32  assembled fetch word.
REQ-014 if_busy  out  1  fetch-side view of busy.
REQ-015 if_done  out  1  one-cycle pulse: fetch complete.
REQ-016 ram_addr  out  32  byte address to RAM.
REQ-017 ram_wr  out  1  1 = write ram_dout at ram_addr this cycle.
REQ-018 ram_dout  out  8  write byte to RAM.
REQ-019 ram_din  in  8  read byte from RAM, valid one cycle after its address was driven with ram_wr=0.

Function
REQ-020 States SHALL be IDLE, RD, WR, DONE; 3-bit byte counter cnt; registered owner flag (ME or IF); base = {addr[31:2],2'b00}, latched at accept.
REQ-021 Requests SHALL be sampled only in IDLE; in any other state, new or held requests are ignored.
REQ-022 IDLE arbitration: ME request (r or w) SHALL win over if_r_enable; IF SHALL wait, with no loss of its request while it stays asserted.
REQ-023 me_w_enable and me_r_enable both high SHALL be treated as a write.
REQ-024 Accept: latch base, owner, mask, write data; cnt<=0; go to WR (write) or RD (read).
REQ-025 RD, cnt=c: ram_wr=0, ram_addr=base+c for c<=3 (base+3 held at c=4); at the edge, for c>=1, ram_din SHALL be stored into lane c-1 of the owner's read buffer; after c=4 go to DONE (RD lasts 5 cycles).
REQ-026 WR, cnt=k (0..3): ram_addr=base+k, ram_dout=lane k of data, ram_wr=mask[k]; after k=3 go to DONE (WR lasts 4 cycles regardless of mask).
REQ-027 mask=0000 write SHALL complete normally in 4+1 cycles with ram_wr never asserted.
REQ-028 DONE: owner's done=1 for exactly this cycle; owner's r_data valid from this cycle; next state IDLE; no accept in DONE.
REQ-029 me_busy and if_busy SHALL both equal (state==RD or state==WR); both low in IDLE and DONE.
REQ-030 me_r_data/if_r_data SHALL change only on completion of a read by that owner, and hold otherwise (writes do not disturb me_r_data).
REQ-031 Lane order little-endian: byte at base+k -> bits [8k+7:8k].
REQ-032 base+k SHALL wrap modulo 2^32; not reachable with k<=3 and an aligned base.
REQ-033 Outside RD/WR: ram_wr=0, ram_addr=0, ram_dout=0.
REQ-034 Latency: accept edge to done pulse = 6 cycles read, 5 cycles write; back-to-back transactions separated by the one IDLE cycle.

Reset
REQ-035 rst=0 SHALL immediately force state=IDLE, cnt=0, all outputs 0 (r_data buffers 0, busy 0, done 0, ram_wr 0), irrespective of clock.
REQ-036 Reset mid-transaction SHALL abort it with no done pulse; remaining RAM writes are not issued; first accept is possible on the first edge after release.

Verification
REQ-037 RAM bytes 0x100..0x103 = 11,22,33,44; me_r_enable, me_addr=0x102 -> ram_addr 0x100..0x103, me_done one cycle, me_r_data=0x44332211, 6 cycles after accept.
REQ-038 me_w_enable, me_addr=0x201, mask=0010, data=0xAAAAAAAA -> exactly one ram_wr at 0x201 with ram_dout=0xAA; me_done after 5 cycles; other bytes unchanged.
REQ-039 if_r_enable and me_r_enable rise together -> ME served first, if_busy high during it, IF served next, if_done comes after me_done, both words correct.
REQ-040 mask=0000 write -> no ram_wr, me_done pulse after 5 cycles.
REQ-041 rst low during RD cnt=2 -> all outputs 0 at once, no me_done; after release, a fresh read returns correct data.
REQ-042 Request held high through DONE -> not re-accepted in DONE; re-accepted in the following IDLE cycle.

Source files
------------

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial RAM controller arbitrating data-side (ME) and fetch-side (IF) word accesses.
// ME wins arbitration; reads assemble 4 little-endian bytes, writes issue per-lane masked byte stores.
module mem_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_me_r_enable,
  input  logic        i_me_w_enable,
  input  logic [3:0]  i_me_w_mask,
  input  logic [31:0] i_me_w_data,
  input  logic [31:0] i_me_addr,
  output logic [31:0] o_me_r_data,
  output logic        o_me_busy,
  output logic        o_me_done,
  input  logic        i_if_r_enable,
  input  logic [31:0] i_if_addr,
  output logic [31:0] o_if_r_data,
  output logic        o_if_busy,
  output logic        o_if_done,
  output logic [31:0] o_ram_addr,
  output logic        o_ram_wr,
  output logic [7:0]  o_ram_dout,
  input  logic [7:0]  i_ram_din
);
  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;
  state_t      r_state, w_next;
  logic [2:0]  r_cnt;
  logic        r_own_if;
  logic [3:0]  r_mask;
  logic [31:0] r_base, r_wdata, r_buf, r_me_rdata, r_if_rdata;
  logic        w_me_req, w_busy;
  logic [1:0]  w_off, w_lane;
  assign w_me_req = i_me_r_enable | i_me_w_enable;
  assign w_busy   = (r_state == RD) || (r_state == WR);
  // RD runs one extra cycle (cnt=4) to capture the last byte; hold the address at base+3
  assign w_off    = (r_cnt > 3'd3) ? 2'd3 : r_cnt[1:0];
  assign w_lane   = r_cnt[1:0] - 2'd1;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: w_next = w_me_req ? (i_me_w_enable ? WR : RD) : (i_if_r_enable ? RD : IDLE);
      RD:   w_next = (r_cnt == 3'd4) ? DONE : RD;
      WR:   w_next = (r_cnt == 3'd3) ? DONE : WR;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_own_if   <= 1'b0;
      r_mask     <= '0;
      r_base     <= '0;
      r_wdata    <= '0;
      r_buf      <= '0;
      r_me_rdata <= '0;
      r_if_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && (w_me_req || i_if_r_enable)) begin
        r_own_if <= !w_me_req;
        r_base   <= w_me_req ? {i_me_addr[31:2], 2'b00} : {i_if_addr[31:2], 2'b00};
        r_mask   <= i_me_w_mask;
        r_wdata  <= i_me_w_data;
        r_cnt    <= '0;
      end else if (w_busy) begin
        r_cnt <= r_cnt + 3'd1;
      end
      if (r_state == RD && r_cnt != 3'd0)
        r_buf[{w_lane, 3'b000} +: 8] <= i_ram_din;
      if (r_state == RD && r_cnt == 3'd4 && r_own_if)
        r_if_rdata <= {i_ram_din, r_buf[23:0]};
      if (r_state == RD && r_cnt == 3'd4 && !r_own_if)
        r_me_rdata <= {i_ram_din, r_buf[23:0]};
    end
  end
  assign o_me_r_data = r_me_rdata;
  assign o_if_r_data = r_if_rdata;
  assign o_me_busy   = w_busy;
  assign o_if_busy   = w_busy;
  assign o_me_done   = (r_state == DONE) && !r_own_if;
  assign o_if_done   = (r_state == DONE) && r_own_if;
  assign o_ram_addr  = w_busy ? r_base + {30'b0, w_off} : 32'd0;
  assign o_ram_wr    = (r_state == WR) && r_mask[w_off];
  assign o_ram_dout  = (r_state == WR) ? r_wdata[{w_off, 3'b000} +: 8] : 8'd0;
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed stimulus with a done-driven scoreboard for mem_ctrl.
// Stimulus pushes expected {owner, word, latency}; the monitor pops on each done pulse.
module tb_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        me_r = 1'b0, me_w = 1'b0, if_r = 1'b0;
  logic [3:0]  me_mask = '0;
  logic [31:0] me_wdata = '0, me_addr = '0, if_addr = '0;
  logic [31:0] me_rdata, if_rdata, ram_addr;
  logic        me_busy, me_done, if_busy, if_done, ram_wr;
  logic [7:0]  ram_dout, ram_din;
  logic [7:0]  mem [0:4095];
  int          cyc = 0, total = 0, bad = 0, wr_cnt = 0;
  logic [31:0] wr_addr;
  logic [7:0]  wr_data;

  typedef struct {bit is_if; logic [31:0] data; int issue; int lat;} exp_t;
  exp_t sb[$];

  mem_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .i_me_r_enable(me_r), .i_me_w_enable(me_w), .i_me_w_mask(me_mask),
    .i_me_w_data(me_wdata), .i_me_addr(me_addr),
    .o_me_r_data(me_rdata), .o_me_busy(me_busy), .o_me_done(me_done),
    .i_if_r_enable(if_r), .i_if_addr(if_addr),
    .o_if_r_data(if_rdata), .o_if_busy(if_busy), .o_if_done(if_done),
    .o_ram_addr(ram_addr), .o_ram_wr(ram_wr), .o_ram_dout(ram_dout), .i_ram_din(ram_din)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: synchronous byte read with one-cycle latency; preload on the first edge
  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
      mem[12'h100] <= 8'h11; mem[12'h101] <= 8'h22; mem[12'h102] <= 8'h33; mem[12'h103] <= 8'h44;
      mem[12'h200] <= 8'h55; mem[12'h201] <= 8'h66; mem[12'h202] <= 8'h77; mem[12'h203] <= 8'h88;
      mem[12'h300] <= 8'h01; mem[12'h301] <= 8'h02; mem[12'h302] <= 8'h03; mem[12'h303] <= 8'h04;
      ram_din <= 8'h00;
    end else begin
      if (ram_wr) mem[ram_addr[11:0]] <= ram_dout;
      ram_din <= mem[ram_addr[11:0]];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (ram_wr) begin
        wr_cnt++;
        wr_addr = ram_addr;
        wr_data = ram_dout;
      end
      if (me_done || if_done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", {30'b0, if_done, me_done}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("done_owner", {31'b0, if_done}, {31'b0, e.is_if});
          check("done_single", {31'b0, me_done & if_done}, 32'd0);
          check("rdata", e.is_if ? if_rdata : me_rdata, e.data);
          check("latency", cyc - e.issue, e.lat);
          check("busy_in_done", {30'b0, me_busy, if_busy}, 32'd0);
        end
      end
    end
  end

  task automatic push(input bit is_if, input logic [31:0] data, input int issue, input int lat);
    exp_t e;
    e.is_if = is_if; e.data = data; e.issue = issue; e.lat = lat;
    sb.push_back(e);
  endtask

  task automatic me_req(input bit w, input logic [31:0] a, input logic [3:0] m,
                        input logic [31:0] d, input logic [31:0] exp_rdata);
    @(negedge clk);
    push(1'b0, exp_rdata, cyc, w ? 5 : 6);
    me_r = !w; me_w = w; me_addr = a; me_mask = m; me_wdata = d;
    @(negedge clk);
    check("first_addr", ram_addr, {a[31:2], 2'b00});
    check("busy_c0", {31'b0, me_busy}, 32'd1);
    me_r = 1'b0; me_w = 1'b0;
  endtask

  task automatic drain(input string name);
    repeat (16) @(negedge clk);
    check(name, sb.size(), 32'd0);
  endtask

  initial begin
    int c;
    #1;
    check("rst_rdata", me_rdata | if_rdata, 32'd0);
    check("rst_ctl", {31'b0, |{ram_addr, ram_dout, ram_wr, me_busy, if_busy, me_done, if_done}}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    me_req(1'b0, 32'h102, 4'h0, 32'h0, 32'h44332211);
    drain("drain_read");

    wr_cnt = 0;
    me_req(1'b1, 32'h201, 4'b0010, 32'hAAAAAAAA, 32'h44332211);
    drain("drain_write");
    check("wr_count", wr_cnt, 32'd1);
    check("wr_addr", wr_addr, 32'h201);
    check("wr_data", {24'b0, wr_data}, 32'hAA);
    check("mem_lanes", {mem[12'h203], mem[12'h202], mem[12'h201], mem[12'h200]}, 32'h8877AA55);

    wr_cnt = 0;
    me_req(1'b1, 32'h300, 4'b0000, 32'hFFFFFFFF, 32'h44332211);
    drain("drain_mask0");
    check("mask0_wr_count", wr_cnt, 32'd0);

    wr_cnt = 0;
    me_req(1'b1, 32'h403, 4'b1111, 32'hDEADBEEF, 32'h44332211);
    drain("drain_full_write");
    check("full_wr_count", wr_cnt, 32'd4);
    me_req(1'b0, 32'h400, 4'h0, 32'h0, 32'hDEADBEEF);
    drain("drain_readback");

    @(negedge clk);
    c = cyc;
    push(1'b0, 32'h44332211, c, 6);
    push(1'b1, 32'h04030201, c, 13);
    me_r = 1'b1; me_addr = 32'h100; if_r = 1'b1; if_addr = 32'h302;
    @(negedge clk);
    me_r = 1'b0;
    @(negedge clk);
    check("if_busy_during_me", {30'b0, if_busy, me_busy}, 32'd3);
    repeat (6) @(negedge clk);
    if_r = 1'b0;
    drain("drain_contention");

    @(negedge clk);
    c = cyc;
    push(1'b0, 32'h04030201, c, 6);
    push(1'b0, 32'h04030201, c, 13);
    me_r = 1'b1; me_addr = 32'h300;
    repeat (8) @(negedge clk);
    me_r = 1'b0;
    drain("drain_hold");

    me_req(1'b0, 32'h100, 4'h0, 32'h0, 32'h0);
    void'(sb.pop_back());
    repeat (2) @(negedge clk);
    check("rd_c2_addr", ram_addr, 32'h102);
    rst_n = 1'b0;
    #1;
    check("abort_rdata", me_rdata | if_rdata, 32'd0);
    check("abort_ctl", {31'b0, |{ram_addr, ram_dout, ram_wr, me_busy, if_busy, me_done, if_done}}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    me_req(1'b0, 32'h101, 4'h0, 32'h0, 32'h44332211);
    drain("drain_after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
